fp_issue_ctrl: RTL and testbench

- Sequences the single-precision FP ALU for the Mini-MIPS core.
- Accepts one FP operation at a time over a valid/ready request port and drives the ALU's operands, funct and cc for a fixed number of cycles.
- Owns the architectural 8-bit FP condition-code register (FCC). The ALU only reports per-op flags; this block keeps them.
- Resolves conditional mov.s against FCC and returns register results over a valid/ready writeback port to the FP register file.

---
 rtl/fp_issue_ctrl.sv | 90 +++++++++
 tb/tb_fp_issue_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: issues one FP op at a time to the ALU, owns the FCC register
// and returns register results over a valid/ready writeback port.
module fp_issue_ctrl #(
    parameter int ALU_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_funct,
    input  logic [2:0]  req_cc,
    input  logic        req_tf,
    input  logic [4:0]  req_fd,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_funct,
    output logic [2:0]  alu_cc,
    input  logic [31:0] alu_result,
    input  logic [7:0]  alu_flags,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_fd,
    output logic [31:0] wb_data,
    output logic [7:0]  fcc,
    output logic        busy,
    output logic        illegal
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic       tf;
    logic [4:0] fd;
    logic       accept, legal, done, is_cmp, wb_op;
    assign req_ready = state == IDLE && !rst;
    assign busy      = state != IDLE;
    assign wb_valid  = state == WB;
    assign accept    = req_valid && req_ready;
    assign legal     = req_funct <= 6'd7;
    assign done      = state == EXEC && cnt == 4'd0;
    assign is_cmp    = alu_funct >= 6'd2 && alu_funct <= 6'd6;
    // add/sub always write back; mov.s only when the selected FCC bit matches tf
    assign wb_op     = alu_funct < 6'd2 || (alu_funct == 6'd7 && fcc[alu_cc] == tf);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept && legal ? EXEC : IDLE;
            EXEC:    state_nx = cnt != 4'd0 ? EXEC : wb_op ? WB : IDLE;
            WB:      state_nx = wb_ready ? IDLE : WB;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fcc       <= '0;
            wb_data   <= '0;
            wb_fd     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_funct <= '0;
            alu_cc    <= '0;
            tf        <= 1'b0;
            fd        <= '0;
            cnt       <= '0;
            illegal   <= 1'b0;
        end else begin
            state   <= state_nx;
            illegal <= accept && !legal;
            if (accept && legal) begin
                alu_a     <= req_a;
                alu_b     <= req_b;
                alu_funct <= req_funct;
                alu_cc    <= req_cc;
                tf        <= req_tf;
                fd        <= req_fd;
                cnt       <= 4'(ALU_LAT - 1);
            end
            if (state == EXEC && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (done && is_cmp)
                fcc[alu_cc] <= alu_flags[alu_cc];
            if (done && wb_op) begin
                wb_data <= alu_result;
                wb_fd   <= fd;
            end
        end
    end
endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb_fp_issue_ctrl: directed bench with a stub ALU and a transaction-level
// reference model compared against the DUT on every falling edge.
module tb_fp_issue_ctrl;
    localparam int L = 2;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_tf = 0, wb_ready = 1;
    logic [5:0]  req_funct = 0;
    logic [2:0]  req_cc = 0;
    logic [4:0]  req_fd = 0;
    logic [31:0] req_a = 0, req_b = 0;
    logic        req_ready, wb_valid, busy, illegal;
    logic [31:0] alu_a, alu_b, alu_result, wb_data;
    logic [5:0]  alu_funct;
    logic [2:0]  alu_cc;
    logic [7:0]  alu_flags, fcc;
    logic [4:0]  wb_fd;
    int pass_cnt = 0, total = 0;
    bit en = 0;

    fp_issue_ctrl #(.ALU_LAT(L)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct(req_funct), .req_cc(req_cc), .req_tf(req_tf), .req_fd(req_fd),
        .req_a(req_a), .req_b(req_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_funct(alu_funct), .alu_cc(alu_cc), .alu_result(alu_result),
        .alu_flags(alu_flags), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_fd(wb_fd), .wb_data(wb_data), .fcc(fcc), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Orders IEEE singles (non-NaN) as unsigned integers.
    function automatic logic [31:0] key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction
    function automatic logic cmp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            6'd2: return a == b;
            6'd3: return key(a) <= key(b);
            6'd4: return key(a) < key(b);
            6'd5: return key(a) >= key(b);
            6'd6: return key(a) > key(b);
            default: return 1'b0;
        endcase
    endfunction
    function automatic logic [31:0] res(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f == 6'd0) return (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : a + b;
        if (f == 6'd1) return a - b;
        if (f == 6'd7) return b;
        return 32'h0;
    endfunction

    assign alu_result = res(alu_funct, alu_a, alu_b);
    assign alu_flags  = 8'(cmp(alu_funct, alu_a, alu_b)) << alu_cc;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    // Reference model: phase 0 idle, 1 op in flight, 2 result waiting for the register file.
    int          ph = 0;
    logic [7:0]  m_fcc = 0;
    logic        m_ill = 0, etf = 0;
    logic [31:0] m_wbd = 0, ea = 0, eb = 0;
    logic [4:0]  m_wbf = 0, efd = 0;
    logic [5:0]  ef = 0;
    logic [2:0]  ecc = 0;
    longint      cyc = 0, t_cap = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = 0; m_fcc = 0; m_ill = 0; m_wbd = 0; m_wbf = 0;
            ea = 0; eb = 0; ef = 0; ecc = 0;
        end else begin
            cyc++;
            m_ill = 0;
            if (ph == 0 && req_valid) begin
                if (req_funct > 6'd7) m_ill = 1;
                else begin
                    ea = req_a; eb = req_b; ef = req_funct; ecc = req_cc;
                    etf = req_tf; efd = req_fd; t_cap = cyc + L; ph = 1;
                end
            end else if (ph == 1 && cyc == t_cap) begin
                if (ef >= 6'd2 && ef <= 6'd6) begin
                    m_fcc[ecc] = cmp(ef, ea, eb);
                    ph = 0;
                end else if (ef < 6'd2 || m_fcc[ecc] == etf) begin
                    m_wbd = res(ef, ea, eb); m_wbf = efd; ph = 2;
                end else ph = 0;
            end else if (ph == 2 && wb_ready) ph = 0;
        end
    end

    always @(negedge clk) if (en) begin
        chk("req_ready", req_ready, ph == 0 && !rst);
        chk("busy", busy, ph != 0);
        chk("wb_valid", wb_valid, ph == 2);
        chk("wb_data", wb_data, m_wbd);
        chk("wb_fd", wb_fd, m_wbf);
        chk("fcc", fcc, m_fcc);
        chk("illegal", illegal, m_ill);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_funct", alu_funct, ef);
        chk("alu_cc", alu_cc, ecc);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [2:0] cc, input logic tf, input logic [4:0] fd,
                         input logic [31:0] a, input logic [31:0] b, input bit hold, output time t);
        bit ok = 0, acc;
        req_funct = f; req_cc = cc; req_tf = tf; req_fd = fd; req_a = a; req_b = b; req_valid = 1;
        t = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk);
            if (acc) begin ok = 1; t = $time; end
        end
        #1;
        if (!ok) begin total++; $display("FAIL accept_timeout: got none expected accept"); end
        if (!hold) req_valid = 0;
    endtask

    task automatic settle();
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
        end
        step();
        if (!ok) begin total++; $display("FAIL idle_timeout: got busy expected idle"); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1);
    end

    initial begin
        time t, ts[4];
        int n, nb;
        repeat (2) step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fcc", fcc, 0);
        rst = 0;
        en = 1;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_fcc", fcc, 8'h00);
        step();
        // add.s with a stalled register file
        wb_ready = 0;
        issue(6'd0, 3'd0, 1'b0, 5'd5, 32'h3F80_0000, 32'h4000_0000, 0, t);
        @(negedge clk); chk("add_busy1", busy, 1); chk("add_wbv1", wb_valid, 0);
        @(negedge clk); chk("add_busy2", busy, 1); chk("add_wbv2", wb_valid, 0);
        @(negedge clk); chk("add_wbv", wb_valid, 1); chk("add_fd", wb_fd, 5); chk("add_data", wb_data, 32'h4040_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("stall_wbv", wb_valid, 1); chk("stall_data", wb_data, 32'h4040_0000);
        end
        step();
        wb_ready = 1;
        @(posedge clk);
        @(negedge clk); chk("wb_done_ready", req_ready, 1); chk("wb_done_wbv", wb_valid, 0);
        step();
        // compares update only their own FCC bit
        issue(6'd4, 3'd3, 1'b0, 5'd0, 32'hBF80_0000, 32'h3F80_0000, 0, t); settle();
        chk("clt_fcc", fcc, 8'h08);
        issue(6'd2, 3'd3, 1'b0, 5'd0, 32'h3F80_0000, 32'h4000_0000, 0, t); settle();
        chk("ceq_fcc", fcc, 8'h00);
        issue(6'd5, 3'd6, 1'b0, 5'd0, 32'h4000_0000, 32'h3F80_0000, 0, t); settle();
        chk("cge_fcc", fcc, 8'h40);
        issue(6'd3, 3'd2, 1'b0, 5'd0, 32'h4000_0000, 32'h4000_0000, 0, t); settle();
        chk("cle_fcc", fcc, 8'h44);
        // conditional moves
        issue(6'd7, 3'd2, 1'b1, 5'd9, 32'h0, 32'hDEAD_BEEF, 0, t); settle();
        chk("mov_t_data", wb_data, 32'hDEAD_BEEF); chk("mov_t_fd", wb_fd, 9);
        issue(6'd7, 3'd2, 1'b0, 5'd10, 32'h0, 32'h1234_5678, 0, t);
        n = 0;
        for (int i = 0; i < L + 2; i++) begin @(negedge clk); n += int'(wb_valid); end
        chk("mov_nt_wbv_count", n, 0);
        chk("mov_nt_ready", req_ready, 1);
        step();
        chk("mov_nt_data", wb_data, 32'hDEAD_BEEF); chk("mov_nt_fd", wb_fd, 9);
        // illegal funct
        issue(6'd12, 3'd1, 1'b0, 5'd1, 32'h1, 32'h2, 0, t);
        n = 0; nb = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); n += int'(illegal); nb += int'(busy); end
        chk("illegal_pulses", n, 1); chk("illegal_busy", nb, 0);
        step();
        chk("illegal_fcc", fcc, 8'h44);
        // back-to-back compares with req_valid held high
        issue(6'd6, 3'd0, 1'b0, 5'd0, 32'h4000_0000, 32'h3F80_0000, 1, ts[0]);
        issue(6'd4, 3'd1, 1'b0, 5'd0, 32'h4000_0000, 32'h3F80_0000, 1, ts[1]);
        issue(6'd2, 3'd7, 1'b0, 5'd0, 32'h3F80_0000, 32'h3F80_0000, 1, ts[2]);
        issue(6'd5, 3'd3, 1'b0, 5'd0, 32'hBF80_0000, 32'h3F80_0000, 0, ts[3]);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(ts[i] - ts[i-1]), 32'((L + 1) * 10));
        settle();
        chk("b2b_fcc", fcc, 8'hC5);
        chk("b2b_fcc_model", fcc, m_fcc);
        // reset mid-operation abandons the add
        issue(6'd0, 3'd0, 1'b0, 5'd3, 32'h3F80_0000, 32'h4000_0000, 0, t);
        @(posedge clk); #3 rst = 1;
        #1;
        chk("arst_wbv", wb_valid, 0); chk("arst_busy", busy, 0);
        chk("arst_fcc", fcc, 0); chk("arst_ready", req_ready, 0); chk("arst_illegal", illegal, 0);
        step();
        rst = 0;
        n = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); n += int'(wb_valid); end
        chk("arst_no_wb", n, 0);
        chk("arst_ready_after", req_ready, 1);
        en = 0;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
